// File: rtl/bnn_accum_threshold.sv
// Accumulates CHUNKS popcount beats per neuron, thresholds each sum into one activation bit
// and packs NEURONS bits into a valid/ready word. Optional BN_SIGN_FLIP_EN adds iFLIP.
module bnn_accum_threshold #(
   parameter  int POP_W   = 11,
   parameter  int CHUNKS  = 4,
   parameter  int NEURONS = 16,
   parameter  int ACC_W   = 13,
   localparam int CW      = (CHUNKS  > 1) ? $clog2(CHUNKS)  : 1,
   localparam int NW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iVALID,
   input  logic [POP_W-1:0]   iPOP,
   input  logic [ACC_W-1:0]   iTHRESH,
`ifdef BN_SIGN_FLIP_EN
   input  logic               iFLIP,
`endif
   input  logic               iREADY,
   output logic [NEURONS-1:0] oACT,
   output logic               oVALID,
   output logic [NW-1:0]      oNEURON,
   output logic [CW-1:0]      oCHUNK,
   output logic               oOVF
);

   typedef enum logic {S_ACC, S_HOLD} state_e;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CW-1:0]      chunk_q, chunk_d;
   logic [NW-1:0]      neuron_q, neuron_d;
   logic [NEURONS-1:0] shift_q, shift_d;
   logic [NEURONS-1:0] act_q, act_d;
   logic               ovf_q, ovf_d;

   logic [ACC_W-1:0]   sum;
   logic               act;
   logic               last_chunk, last_neuron, word_done, load;
   logic [NEURONS-1:0] word;

   assign sum         = acc_q + ACC_W'(iPOP);
   assign last_chunk  = (chunk_q == CW'(CHUNKS-1));
   assign last_neuron = (neuron_q == NW'(NEURONS-1));
   assign word_done   = iVALID && last_chunk && last_neuron;
   // A finished word is taken unless the previous one is still pending and not accepted now.
   assign load        = word_done && ((state_q == S_ACC) || iREADY);

`ifdef BN_SIGN_FLIP_EN
   assign act = iFLIP ? (sum <= iTHRESH) : (sum >= iTHRESH);
`else
   assign act = (sum >= iTHRESH);
`endif

   always_comb begin
      word              = shift_q;
      word[NEURONS-1]   = act;
   end

   // state register and datapath registers
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q  <= S_ACC;
         acc_q    <= '0;
         chunk_q  <= '0;
         neuron_q <= '0;
         shift_q  <= '0;
         act_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         chunk_q  <= chunk_d;
         neuron_q <= neuron_d;
         shift_q  <= shift_d;
         act_q    <= act_d;
         ovf_q    <= ovf_d;
      end
   end

   // next-state and datapath update
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      chunk_d  = chunk_q;
      neuron_d = neuron_q;
      shift_d  = shift_q;
      act_d    = act_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_ACC:   if (word_done)   state_d = S_HOLD;
         S_HOLD:  if (!word_done && iREADY) state_d = S_ACC;
         default: state_d = S_ACC;
      endcase

      if (iVALID) begin
         if (last_chunk) begin
            acc_d   = '0;
            chunk_d = '0;
            if (last_neuron) begin
               shift_d  = '0;
               neuron_d = '0;
            end else begin
               shift_d[neuron_q] = act;
               neuron_d          = neuron_q + NW'(1);
            end
         end else begin
            acc_d   = sum;
            chunk_d = chunk_q + CW'(1);
         end
      end

      if (load) act_d = word;
      if (word_done && (state_q == S_HOLD) && !iREADY) ovf_d = 1'b1;
   end

   // outputs
   always_comb begin
      oVALID  = (state_q == S_HOLD);
      oACT    = act_q;
      oNEURON = neuron_q;
      oCHUNK  = chunk_q;
      oOVF    = ovf_q;
   end

endmodule

// File: tb/tb_bnn_accum_threshold.sv
// Scoreboard bench for bnn_accum_threshold: expected words are queued as beats are driven
// and compared whenever the DUT holds or hands off a word.
module tb_bnn_accum_threshold;

   logic        iCLK = 1'b0;
   logic        iRST, iVALID, iREADY, iFLIP;
   logic [10:0] iPOP;
   logic [12:0] iTHRESH;
   logic [15:0] oACT;
   logic        oVALID, oOVF;
   logic [3:0]  oNEURON;
   logic [1:0]  oCHUNK;

   int vectors = 0;
   int miscompares = 0;
   bit rdy = 1'b1;

   // reference model state
   int          macc, mchunk, mneur;
   logic [15:0] mshift;
   bit          mvalid, movf;
   logic [15:0] sb[$];

   always #5 iCLK = ~iCLK;

   bnn_accum_threshold dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iVALID  (iVALID),
      .iPOP    (iPOP),
      .iTHRESH (iTHRESH),
`ifdef BN_SIGN_FLIP_EN
      .iFLIP   (iFLIP),
`endif
      .iREADY  (iREADY),
      .oACT    (oACT),
      .oVALID  (oVALID),
      .oNEURON (oNEURON),
      .oCHUNK  (oCHUNK),
      .oOVF    (oOVF)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      macc = 0; mchunk = 0; mneur = 0; mshift = '0;
      mvalid = 0; movf = 0;
      sb.delete();
   endtask

   // One clock: drive at negedge, update model, check #1 after the rising edge.
   task automatic step(input bit v, input int pop, input int thr, input bit fl);
      int  s;
      bit  a, done;
      logic [15:0] w;
      @(negedge iCLK);
      iVALID = v; iPOP = pop[10:0]; iTHRESH = thr[12:0]; iFLIP = fl; iREADY = rdy;
      done = 0;
      w    = '0;
      if (mvalid && rdy && sb.size() > 0) void'(sb.pop_front());
      if (v) begin
         s = macc + pop;
         if (mchunk == 3) begin
            a = fl ? (s <= thr) : (s >= thr);
            mshift[mneur] = a;
            macc = 0; mchunk = 0;
            if (mneur == 15) begin
               done = 1; w = mshift; mshift = '0; mneur = 0;
            end else mneur++;
         end else begin
            macc = s; mchunk++;
         end
      end
      if (done) begin
         if (mvalid && !rdy) movf = 1;
         else sb.push_back(w);
         mvalid = 1;
      end else if (mvalid && rdy) mvalid = 0;
      @(posedge iCLK);
      #1;
      chk("valid",  oVALID,  mvalid);
      chk("ovf",    oOVF,    movf);
      chk("neuron", oNEURON, mneur);
      chk("chunk",  oCHUNK,  mchunk);
      if (mvalid) chk("word", oACT, (sb.size() > 0) ? sb[0] : 16'hxxxx);
   endtask

   task automatic neuron(input int a, input int b, input int thr, input bit fl);
      step(1, a, thr, fl); step(1, b, thr, fl);
      step(1, a, thr, fl); step(1, b, thr, fl);
   endtask

   task automatic full_word_5555();
      for (int n = 0; n < 16; n++) neuron(n, 0, (n % 2) ? 2*n+1 : 2*n, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   // Reset asserted between edges; outputs must clear without waiting for a clock.
   task automatic areset();
      @(negedge iCLK);
      #1 iRST = 1'b1; iVALID = 1'b0;
      #1;
      chk("rst_valid",  oVALID,  0);
      chk("rst_act",    oACT,    0);
      chk("rst_ovf",    oOVF,    0);
      chk("rst_neuron", oNEURON, 0);
      chk("rst_chunk",  oCHUNK,  0);
      model_reset();
      @(negedge iCLK);
      iRST = 1'b0;
   endtask

   initial begin
      iRST = 1'b1; iVALID = 0; iPOP = 0; iTHRESH = 0; iFLIP = 0; iREADY = 1;
      model_reset();
      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      iRST = 1'b0;

      // partial neuron, then async reset and idle
      step(1, 5, 0, 0); step(1, 5, 0, 0);
      areset();
      idle(20);

      // single neuron at and just above threshold
      neuron(100, 100, 400, 0);
      repeat (15) neuron(0, 0, 1, 0);
      chk("single_pass", oACT, 16'h0001);
      idle(2);
      neuron(100, 100, 401, 0);
      repeat (15) neuron(0, 0, 1, 0);
      chk("single_fail", oACT, 16'h0000);
      idle(2);

      // full word, even neurons pass
      full_word_5555();
      chk("full_word",  oACT,   16'h5555);
      chk("full_valid", oVALID, 1);
      chk("full_ovf",   oOVF,   0);
      idle(2);

      // backpressure across two words
      rdy = 0;
      full_word_5555();
      repeat (16) neuron(1, 1, 4, 0);
      chk("ovf_flag", oOVF, 1);
      chk("ovf_hold", oACT, 16'h5555);
      rdy = 1;
      idle(1);
      chk("ovf_drain", oVALID, 0);
      areset();

      // accept on the same edge as the next word completes
      rdy = 0;
      full_word_5555();
      repeat (15) neuron(1, 1, 4, 0);
      step(1, 1, 4, 0); step(1, 1, 4, 0); step(1, 1, 4, 0);
      rdy = 1;
      step(1, 1, 4, 0);
      chk("same_edge_act",   oACT,   16'hFFFF);
      chk("same_edge_valid", oVALID, 1);
      chk("same_edge_ovf",   oOVF,   0);
      idle(2);

      // maximum sum must not wrap
      neuron(2047, 2047, 8188, 0);
      repeat (15) neuron(0, 0, 0, 0);
      chk("max_word", oACT, 16'hFFFF);
      idle(2);

      // reset part way through a word
      neuron(1, 1, 0, 0);
      step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
      areset();
      neuron(3, 3, 13, 0);
      chk("post_rst_neuron", oNEURON, 1);
      chk("post_rst_chunk",  oCHUNK,  0);
      repeat (15) neuron(0, 0, 0, 0);
      chk("post_rst_word", oACT, 16'hFFFE);
      idle(2);

`ifdef BN_SIGN_FLIP_EN
      neuron(100, 100, 400, 1);
      neuron(100, 100, 399, 1);
      repeat (14) neuron(0, 0, 1, 0);
      chk("flip_word", oACT, 16'h0001);
      idle(2);
`endif

      idle(2);
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bnn_accum_threshold.md
Name: bnn_accum_threshold

Overview:
- Downstream consumer of the 112-bit XNOR/popcount stage.
- Sums CHUNKS consecutive 11-bit popcounts per neuron and compares the total with a per-neuron threshold (batch-norm folded) to give one binary activation bit.
- Packs NEURONS activation bits into one word and offers it to the next layer with a valid/ready handshake.

Parameters:
- POP_W, 11, width of incoming popcount.
- CHUNKS, 4, popcount beats per neuron (4 x 112 = 448 inputs per neuron).
- NEURONS, 16, activation bits per packed output word.
- ACC_W, 13, accumulator width; must satisfy 2^ACC_W > CHUNKS*(2^POP_W-1).

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  asynchronous active-high reset.
- iVALID  in  1  iPOP is valid this cycle (popcount stage output strobe).
- iPOP  in  POP_W  popcount value.
- iTHRESH  in  ACC_W  threshold for the current neuron; sampled only on the last chunk beat.
- iREADY  in  1  downstream accepts oACT.
- oACT  out  NEURONS  packed activations; bit n = neuron n.
- oVALID  out  1  oACT holds an unconsumed word.
- oNEURON  out  log2(NEURONS) (min 1)  index of the neuron being accumulated.
- oCHUNK  out  log2(CHUNKS) (min 1)  index of the next expected chunk.
- oOVF  out  1  sticky: a completed word was dropped.

Behaviour:
- Reset (async, iRST=1): acc=0, chunk_cnt=0, neuron_cnt=0, shift=0, oACT=0, oVALID=0, oOVF=0. Reset mid-neuron or mid-word discards the partial work. There is no recovery path.
- Beat: iVALID=1 at a rising edge. Without a beat, all state holds.
- Accumulate: sum = acc + zero-extend(iPOP). On a non-last chunk, acc<=sum and chunk_cnt++.
- Last chunk (chunk_cnt==CHUNKS-1):
  - act = (sum >= iTHRESH), unsigned compare.
  - shift[neuron_cnt] <= act; acc<=0; chunk_cnt<=0; neuron_cnt++.
- Word complete (last chunk and neuron_cnt==NEURONS-1):
  - oACT <= shift with act merged into bit NEURONS-1; shift<=0; neuron_cnt<=0.
  - oVALID<=1 one cycle after the final beat. Latency from final beat to oVALID is 1 clock.
- Handshake:
  - oVALID&&iREADY at an edge: oVALID<=0 unless a new word completes on the same edge.
  - Same-edge complete + accept: new word loads, oVALID stays 1, no overflow.
  - oACT stays stable while oVALID=1 and not accepted.
- Overflow: a word completes while oVALID=1 and iREADY=0. The new word is dropped, the old oACT is kept, and oOVF<=1 (sticky until reset).
- Input is never back-pressured; the upstream stream is free-running.
- State machine, two states:
  - ACC: counting beats.
  - HOLD: oVALID=1, word pending.
  - Accumulation continues in both states. HOLD->ACC on accept without a new completion.
- Width: the accumulator cannot wrap if the ACC_W rule holds. Max case is 4*2047=8188 < 8192 with defaults.
- CHUNKS=1: every beat is a last beat. NEURONS=1: every neuron completes a word. Both must be supported.

Optional Feature:
- BN_SIGN_FLIP_EN. When defined, adds input port iFLIP (1 bit), sampled together with iTHRESH. Rule: act = iFLIP ? (sum <= iTHRESH) : (sum >= iTHRESH). This covers negative batch-norm gamma.
- When undefined: port absent, act = (sum >= iTHRESH).

Test Plan:
- Reset then idle: iRST pulse mid-cycle -> all outputs 0 immediately, asynchronously; 20 idle cycles -> oVALID stays 0.
- Single neuron: beats iPOP=100,100,100,100 with iTHRESH=400 -> shift bit0=1. Rerun with iTHRESH=401 -> bit0=0.
- Full word: 64 back-to-back beats, neuron n sums to 2n with thresholds alternating so that even n pass -> oACT=16'h5555, oVALID one cycle after beat 64, oOVF=0.
- Backpressure overflow: iREADY=0 across two complete words -> first word held, oOVF=1, oACT=first word. iREADY=1 -> oVALID drops next cycle.
- Same-edge accept and complete: iREADY=1 exactly on the edge of the final beat of word 2 -> oACT=word 2, oVALID stays 1, oOVF=0.
- Max value and reset mid-word: four beats of iPOP=2047 with iTHRESH=8188 -> act=1, no wrap. Then iRST after 3 beats of the next neuron -> counters 0, and the next 4 beats form neuron 0. With BN_SIGN_FLIP_EN and iFLIP=1: sum 400, thresh 400 -> act=1; thresh 399 -> act=0.
